// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: FSM state encoding, forwarding-select codes
//                and the default multi-cycle MDU latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   // Hazard-controller sequencing states
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } state_t;

   // Operand source select codes
   localparam logic [1:0] FWD_RF    = 2'b00;  // register file
   localparam logic [1:0] FWD_EXE   = 2'b01;  // EXE-stage ALU result
   localparam logic [1:0] FWD_MEM   = 2'b10;  // MEM-stage ALU result
   localparam logic [1:0] FWD_MEMLD = 2'b11;  // MEM-stage load data

   // Default busy time of a multiply/divide operation
   localparam int DEF_MDU_CYCLES = 32;

endpackage
`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_fwd_sel
//  Description : Operand forwarding select for one ID-stage source register.
//                The younger producer in EXE wins over the one in MEM; a load
//                still in EXE cannot forward (that case is a load-use stall).
//  Ports       : src                  - ID-stage source register number
//                ern, ewreg, em2reg   - EXE destination / write / load flag
//                mrn, mwreg, mm2reg   - MEM destination / write / load flag
//                fwd                  - source select (FWD_* codes)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_fwd_sel
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] ern,
   input  logic       ewreg,
   input  logic       em2reg,
   input  logic [4:0] mrn,
   input  logic       mwreg,
   input  logic       mm2reg,
   output logic [1:0] fwd
);

   logic w_exe_hit;
   logic w_mem_hit;

   // r0 is hard-wired zero, so a write to it never forwards
   assign w_exe_hit = ewreg & ~em2reg & (ern != 5'd0) & (ern == src);
   assign w_mem_hit = mwreg & (mrn != 5'd0) & (mrn == src);

   always_comb begin
      fwd = FWD_RF;
      if (w_exe_hit) begin
         fwd = FWD_EXE;
      end else if (w_mem_hit) begin
         fwd = mm2reg ? FWD_MEMLD : FWD_MEM;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline hazard controller. Generates operand forwarding
//                selects, load-use stall, taken-branch IF/ID flush and the
//                stall sequence of a multi-cycle multiply/divide unit.
//  Config      : PIPE_HAZARD_MDU_EN - when defined, MDU sequencing (busy /
//                done states and cycle counter) is built; otherwise
//                dmdu_start is ignored and mdu_busy/mdu_done stay 0.
//  Parameters  : MDU_CYCLES - MDU busy cycles (2..64)
//  Ports       : clk, clrn            - clock, async active-low reset
//                drs, drt             - ID source registers
//                duse_rs, duse_rt     - ID instruction reads rs / rt
//                dbr_taken            - ID branch/jump taken
//                dmdu_start           - ID instruction is an MDU op
//                ern, ewreg, em2reg   - EXE destination / write / load
//                mrn, mwreg, mm2reg   - MEM destination / write / load
//                wpcir                - PC and IF/ID write enable
//                dbubble              - bubble into ID/EXE
//                ifid_flush           - IF/ID instruction -> NOP
//                fwda, fwdb           - operand A/B source select
//                mdu_busy, mdu_done   - MDU in progress / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_CYCLES = DEF_MDU_CYCLES
)
(
   input  logic       clk,
   input  logic       clrn,
   input  logic [4:0] drs,
   input  logic [4:0] drt,
   input  logic       duse_rs,
   input  logic       duse_rt,
   input  logic       dbr_taken,
   input  logic       dmdu_start,
   input  logic [4:0] ern,
   input  logic [4:0] mrn,
   input  logic       ewreg,
   input  logic       em2reg,
   input  logic       mwreg,
   input  logic       mm2reg,
   output logic       wpcir,
   output logic       dbubble,
   output logic       ifid_flush,
   output logic [1:0] fwda,
   output logic [1:0] fwdb,
   output logic       mdu_busy,
   output logic       mdu_done
);

   logic w_lu;
   logic w_run;
   logic w_busy;

   // ------------------------------------------------------------------
   // Forwarding selects
   // ------------------------------------------------------------------
   pipe_fwd_sel u_fwd_a (
      .src    (drs),
      .ern    (ern),
      .ewreg  (ewreg),
      .em2reg (em2reg),
      .mrn    (mrn),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .fwd    (fwda)
   );

   pipe_fwd_sel u_fwd_b (
      .src    (drt),
      .ern    (ern),
      .ewreg  (ewreg),
      .em2reg (em2reg),
      .mrn    (mrn),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .fwd    (fwdb)
   );

   // Load in EXE whose result the ID instruction needs: data not yet
   // available for forwarding, so ID must wait one cycle.
   assign w_lu = ewreg & em2reg & (ern != 5'd0) &
                 ((duse_rs & (ern == drs)) | (duse_rt & (ern == drt)));

`ifdef PIPE_HAZARD_MDU_EN
   // ------------------------------------------------------------------
   // MDU sequencing
   // ------------------------------------------------------------------
   localparam int                c_CNT_W    = $clog2(MDU_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MDU_CYCLES - 1);

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_mdu_busy;
   logic                 r_mdu_done;

   // Counter holds cycles remaining after the current one; the busy state
   // is therefore occupied for exactly MDU_CYCLES cycles.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state    <= RUN;
         r_cnt      <= '0;
         r_mdu_busy <= 1'b0;
         r_mdu_done <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               // A pending load-use stall blocks the MDU start; the op is
               // re-presented in ID on the following cycle.
               if (dmdu_start && !w_lu) begin
                  r_state    <= MDU_BUSY;
                  r_cnt      <= c_CNT_LOAD;
                  r_mdu_busy <= 1'b1;
               end
            end
            MDU_BUSY: begin
               if (r_cnt == '0) begin
                  r_state    <= MDU_DONE;
                  r_mdu_busy <= 1'b0;
                  r_mdu_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            MDU_DONE: begin
               r_state    <= RUN;
               r_mdu_done <= 1'b0;
            end
            default: begin
               r_state    <= RUN;
               r_cnt      <= '0;
               r_mdu_busy <= 1'b0;
               r_mdu_done <= 1'b0;
            end
         endcase
      end
   end

   assign w_run    = (r_state == RUN);
   assign w_busy   = (r_state == MDU_BUSY);
   assign mdu_busy = r_mdu_busy;
   assign mdu_done = r_mdu_done;
`else
   // No MDU support: controller is permanently in RUN.
   localparam int c_unused_mdu_cycles = MDU_CYCLES;
   logic w_unused_mdu_start;

   assign w_unused_mdu_start = dmdu_start;
   assign w_run              = 1'b1;
   assign w_busy             = 1'b0;
   assign mdu_busy           = 1'b0;
   assign mdu_done           = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Stall / bubble / flush
   // ------------------------------------------------------------------
   // Outside RUN and BUSY (i.e. MDU_DONE) the defaults let the pipe
   // advance with no flush: a branch seen then is ignored.
   always_comb begin
      wpcir      = 1'b1;
      dbubble    = 1'b0;
      ifid_flush = 1'b0;
      if (w_run) begin
         wpcir      = ~w_lu;
         dbubble    = w_lu;
         ifid_flush = dbr_taken & ~w_lu;
      end else if (w_busy) begin
         wpcir      = 1'b0;
         dbubble    = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_CYCLES, default 32, the number of busy cycles of a multi-cycle multiply/divide op (legal range 2..64).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- clrn  in  1  asynchronous, active-low reset.
- drs, drt  in  5 each  ID-stage source register numbers.
- duse_rs, duse_rt  in  1 each  ID instruction reads rs / rt.
- dbr_taken  in  1  ID-stage branch or jump resolved taken.
- dmdu_start  in  1  ID instruction is a multi-cycle MDU op.
- ern, mrn  in  5 each  EXE / MEM destination register.
- ewreg, em2reg, mwreg, mm2reg  in  1 each  EXE/MEM write-enable and load flags.
- wpcir  out  1  PC and IF/ID write enable (0 = hold).
- dbubble  out  1  zero the control fields entering the ID/EXE register.
- ifid_flush  out  1  replace the IF/ID instruction with a NOP.
- fwda, fwdb  out  2 each  operand-A/B source select.
- mdu_busy  out  1  MDU sequence in progress.
- mdu_done  out  1  one-cycle pulse on MDU completion.

Function
REQ-003 fwdX encoding SHALL be: 00 register file; 01 EXE ALU result; 10 MEM ALU result; 11 MEM load data.
REQ-004 fwdX SHALL be 01 when ewreg & !em2reg & ern!=0 & ern==src. Otherwise it SHALL be 10 or 11 when mwreg & mrn!=0 & mrn==src, with 11 iff mm2reg. Otherwise 00. EXE match SHALL win over MEM match.
REQ-005 Load-use hazard lu SHALL be asserted when ewreg & em2reg & ern!=0 & ((duse_rs & ern==drs) | (duse_rt & ern==drt)).
REQ-006 The FSM SHALL have exactly three states: RUN, MDU_BUSY, MDU_DONE.
REQ-007 In RUN, the outputs SHALL be:
- wpcir = !lu
- dbubble = lu
- ifid_flush = dbr_taken & !lu
REQ-008 In RUN with dmdu_start & !lu, the block SHALL load the counter with MDU_CYCLES-1 and go to MDU_BUSY next cycle. With dmdu_start & lu, it SHALL stay in RUN (the load stall takes priority).
REQ-009 In MDU_BUSY, the block SHALL drive wpcir=0, dbubble=1, ifid_flush=0 and mdu_busy=1, and SHALL decrement the counter each cycle. When the counter is 0, it SHALL go to MDU_DONE.
REQ-010 MDU_DONE SHALL last one cycle, drive mdu_done=1, mdu_busy=0, wpcir=1, dbubble=0, and then return to RUN unconditionally.
REQ-011 dbr_taken and dmdu_start SHALL be ignored outside RUN.
REQ-012 Total stall for an MDU op SHALL be MDU_CYCLES cycles of wpcir=0.
REQ-013 The counter SHALL be $clog2(MDU_CYCLES) bits wide and SHALL never wrap: decrement is only enabled when the counter is non-zero.

Reset
REQ-014 When clrn=0, the block SHALL immediately force state=RUN, counter=0, mdu_busy=0 and mdu_done=0, including mid-MDU sequence.
REQ-015 With clrn=0 and all inputs 0, the outputs SHALL be wpcir=1, dbubble=0, ifid_flush=0, fwda=fwdb=00.
REQ-016 On clrn deassertion, the first clk edge SHALL evaluate from RUN.

Configuration
REQ-017 Macro PIPE_HAZARD_MDU_EN SHALL control MDU support.
- Defined: MDU_BUSY, MDU_DONE and the counter are present, per REQ-008..REQ-013.
- Undefined: dmdu_start is ignored, the FSM is RUN only, mdu_busy=mdu_done=0 constantly, and no counter is synthesised.

Structure
REQ-018 Package pipe_ctrl_pkg SHALL hold:
- the FSM state typedef;
- the constants FWD_RF, FWD_EXE, FWD_MEM, FWD_MEMLD;
- the default MDU_CYCLES.
REQ-019 Forwarding select SHALL be a sub-module pipe_fwd_sel, instantiated twice (operand A, operand B).
REQ-020 The FSM, counter and stall/flush logic SHALL reside in pipe_hazard_ctrl.

Verification
REQ-021 The bench SHALL cover at least the following directed scenarios:
- EXE forward: ewreg=1, em2reg=0, ern=5, drs=5, duse_rs=1 -> fwda=01, wpcir=1.
- EXE precedence: ern=mrn=7 both writing, drt=7 -> fwdb=01. With ewreg=0 and mm2reg=1 -> fwdb=11. With drs=0 and all matches -> fwda=00.
- Load-use: em2reg=1, ewreg=1, ern=3, drt=3, duse_rt=1, dbr_taken=1 -> one cycle of wpcir=0, dbubble=1, ifid_flush=0. Next cycle (load moved to MEM) -> fwdb=11, ifid_flush=1.
- MDU, MDU_CYCLES=4: pulse dmdu_start -> mdu_busy=1 for 4 cycles, wpcir=0 for 4 cycles, then mdu_done=1 for 1 cycle, then RUN. dbr_taken held high throughout -> ifid_flush=0 until RUN.
- Reset mid-MDU: clrn=0 on the second busy cycle -> mdu_busy=0 and wpcir=1 asynchronously. After release, dmdu_start=0 -> the block stays in RUN.
- Macro undefined: dmdu_start=1 for 10 cycles -> wpcir=1, mdu_busy=0 throughout.
